// File: rtl/digit_serial_cpa_if.sv
// rtl/digit_serial_cpa_if.sv - start/valid operand and result bundle for digit_serial_cpa
interface digit_serial_cpa_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b, c_in,
        input  ready, valid, s, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output ready, valid, s, c_out, ovf
    );
endinterface

// File: rtl/digit_serial_cpa.sv
// rtl/digit_serial_cpa.sv - digit-serial carry-propagate adder/subtractor, DIGIT bits per clock
// Optional feature: define DSA_SAT_EN to clamp s to the signed extreme on overflow.
module digit_serial_cpa #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    digit_serial_cpa_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IW-1:0]    base;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] s_fin;
    logic             last;
    logic             accept;
    logic             ovf_fin;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        ready_d = ready_q;
        cnt_d   = cnt_q;

        // One DIGIT-wide ripple stage, steered onto the current slice by the counter.
        base    = IW'(cnt_q * DIGIT);
        sum     = {1'b0, a_q[base +: DIGIT]} + {1'b0, b_q[base +: DIGIT]}
                + {{DIGIT{1'b0}}, carry_q};
        r_next  = r_q;
        r_next[base +: DIGIT] = sum[DIGIT-1:0];
        last    = (cnt_q == CW'(N - 1));
        accept  = bus.start && ready_q;
        ovf_fin = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_next[WIDTH-1] != a_q[WIDTH-1]);

`ifdef DSA_SAT_EN
        if (ovf_fin) begin
            s_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            s_fin = r_next;
        end
`else
        s_fin = r_next;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.c_in ^ bus.sub;
                    cnt_d   = '0;
                    r_d     = '0;
                    ready_d = 1'b0;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                r_d     = r_next;
                carry_d = sum[DIGIT];
                if (last) begin
                    state_d = DONE;
                    s_d     = s_fin;
                    c_out_d = sum[DIGIT];
                    ovf_d   = ovf_fin;
                    valid_d = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
    assign bus.valid = valid_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_digit_serial_cpa.sv
// tb/tb_digit_serial_cpa.sv - randomized self-checking bench for digit_serial_cpa
module tb_digit_serial_cpa;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    digit_serial_cpa_if #(.WIDTH(8))  if84 ();
    digit_serial_cpa_if #(.WIDTH(8))  if81 ();
    digit_serial_cpa_if #(.WIDTH(16)) if168 ();

    digit_serial_cpa #(.WIDTH(8),  .DIGIT(4)) u84  (.clk(clk), .rst_n(rst_n), .bus(if84));
    digit_serial_cpa #(.WIDTH(8),  .DIGIT(1)) u81  (.clk(clk), .rst_n(rst_n), .bus(if81));
    digit_serial_cpa #(.WIDTH(16), .DIGIT(8)) u168 (.clk(clk), .rst_n(rst_n), .bus(if168));

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    // Signed/unsigned integer arithmetic on the operands, no digit view.
    function automatic res_t ref_model(int w, longint a, longint b, bit cin, bit sb);
        res_t   r;
        longint m, half, sa, sbv, full, ideal;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - (m + 1) : a;
        sbv  = (b >= half) ? b - (m + 1) : b;
        if (!sb) begin
            full  = a + b + longint'(cin);
            r.c   = ((full >> w) & 1) != 0;
            ideal = sa + sbv + longint'(cin);
        end else begin
            full  = a - b - longint'(cin);
            r.c   = (a >= b + longint'(cin));
            ideal = sa - sbv - longint'(cin);
        end
        r.s = 16'(full & m);
        r.v = (ideal > half - 1) || (ideal < -half);
`ifdef DSA_SAT_EN
        if (r.v) r.s = (ideal > half - 1) ? 16'(half - 1) : 16'(half);
`endif
        return r;
    endfunction

    task automatic op84(input logic [7:0] a, b, input logic cin, sb,
                        output int lat, output logic [7:0] s, output logic c, v);
        @(negedge clk);
        if84.start = 1'b1; if84.a = a; if84.b = b; if84.c_in = cin; if84.sub = sb;
        @(negedge clk);
        if84.start = 1'b0; if84.a = 8'($urandom); if84.b = 8'($urandom);
        lat = 0;
        while (!if84.valid && lat < 40) begin @(negedge clk); lat++; end
        s = if84.s; c = if84.c_out; v = if84.ovf;
    endtask

    task automatic op81(input logic [7:0] a, b, input logic cin, sb,
                        output int lat, output logic [7:0] s, output logic c, v);
        @(negedge clk);
        if81.start = 1'b1; if81.a = a; if81.b = b; if81.c_in = cin; if81.sub = sb;
        @(negedge clk);
        if81.start = 1'b0;
        lat = 0;
        while (!if81.valid && lat < 40) begin @(negedge clk); lat++; end
        s = if81.s; c = if81.c_out; v = if81.ovf;
    endtask

    task automatic op168(input logic [15:0] a, b, input logic cin, sb,
                         output int lat, output logic [15:0] s, output logic c, v);
        @(negedge clk);
        if168.start = 1'b1; if168.a = a; if168.b = b; if168.c_in = cin; if168.sub = sb;
        @(negedge clk);
        if168.start = 1'b0;
        lat = 0;
        while (!if168.valid && lat < 40) begin @(negedge clk); lat++; end
        s = if168.s; c = if168.c_out; v = if168.ovf;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        if84.start = 1'b1; if84.a = 8'($urandom); if84.b = 8'($urandom);
        if84.c_in = 1'($urandom); if84.sub = 1'($urandom);
        #1;
        checks++; if (if84.s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h expected 00", if84.s); end
        checks++; if (if84.c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b expected 0", if84.c_out); end
        checks++; if (if84.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", if84.ovf); end
        checks++; if (if84.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if84.valid); end
        checks++; if (if84.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", if84.ready); end
        checks++; if ({if81.ready, if168.ready, if81.valid, if168.valid} !== 4'b1100)
            begin errors++; $display("FAIL reset_others: got %b expected 1100", {if81.ready, if168.ready, if81.valid, if168.valid}); end
        repeat (3) @(negedge clk);
        checks++; if (if84.valid !== 1'b0 || if84.ready !== 1'b1)
            begin errors++; $display("FAIL reset_hold: got valid=%b ready=%b expected 0/1", if84.valid, if84.ready); end
        if84.start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic [7:0] s; logic c, v; logic [7:0] exp_s;
`ifdef DSA_SAT_EN
        exp_s = 8'h7F;
`else
        exp_s = 8'h92;
`endif
        op84(8'h3C, 8'h55, 1'b1, 1'b0, lat, s, c, v);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (s !== exp_s) begin errors++; $display("FAIL add_s: got %h expected %h", s, exp_s); end
        checks++; if ({c, v} !== 2'b01) begin errors++; $display("FAIL add_flags: got c=%b ovf=%b expected 0/1", c, v); end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] s; logic c, v;
        op84(8'h10, 8'h20, 1'b0, 1'b1, lat, s, c, v);
        checks++; if ({s, c, v} !== {8'hF0, 2'b00}) begin errors++; $display("FAIL sub_borrow: got s=%h c=%b ovf=%b expected F0/0/0", s, c, v); end
        op84(8'h20, 8'h10, 1'b1, 1'b1, lat, s, c, v);
        checks++; if ({s, c, v} !== {8'h0F, 2'b10}) begin errors++; $display("FAIL sub_noborrow: got s=%h c=%b ovf=%b expected 0F/1/0", s, c, v); end
    endtask

    task automatic test_random_84();
        int lat; logic [7:0] s, a, b; logic c, v, cin, sb; res_t e;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sb = 1'($urandom);
            if (i == 0) begin a = 8'h80; b = 8'h01; sb = 1'b1; cin = 1'b0; end
            if (i == 1) begin a = 8'h7F; b = 8'h7F; sb = 1'b0; cin = 1'b1; end
            e = ref_model(8, longint'(a), longint'(b), cin, sb);
            op84(a, b, cin, sb, lat, s, c, v);
            checks++; if (lat !== 2 || {s, c, v} !== {e.s[7:0], e.c, e.v})
                begin errors++; $display("FAIL rand84_%0d: got lat=%0d s=%h c=%b ovf=%b expected 2 %h %b %b", i, lat, s, c, v, e.s[7:0], e.c, e.v); end
        end
        @(negedge clk);
        checks++; if (if84.valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", if84.valid); end
    endtask

    task automatic test_ignore_start();
        res_t e; int nval;
        e = ref_model(8, 64'h5A, 64'hC3, 1'b0, 1'b0);
        @(negedge clk);
        if84.start = 1'b1; if84.a = 8'h5A; if84.b = 8'hC3; if84.c_in = 1'b0; if84.sub = 1'b0;
        @(negedge clk);
        if84.start = 1'b0;
        checks++; if (if84.ready !== 1'b0) begin errors++; $display("FAIL run_ready: got %b expected 0", if84.ready); end
        @(negedge clk);
        if84.start = 1'b1; if84.a = 8'h11; if84.b = 8'h22; if84.c_in = 1'b1; if84.sub = 1'b1;
        @(negedge clk);
        if84.start = 1'b0;
        checks++; if (if84.valid !== 1'b1 || {if84.s, if84.c_out, if84.ovf} !== {e.s[7:0], e.c, e.v})
            begin errors++; $display("FAIL ignore_start: got valid=%b s=%h c=%b ovf=%b expected 1 %h %b %b", if84.valid, if84.s, if84.c_out, if84.ovf, e.s[7:0], e.c, e.v); end
        nval = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (if84.valid) nval++; end
        checks++; if (nval !== 0 || if84.s !== e.s[7:0])
            begin errors++; $display("FAIL ignore_no_queue: got %0d pulses s=%h expected 0 pulses s=%h", nval, if84.s, e.s[7:0]); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] s; logic c, v; res_t e1, e2;
        e1 = ref_model(8, 64'hE7, 64'h39, 1'b1, 1'b1);
        e2 = ref_model(8, 64'h64, 64'h2B, 1'b1, 1'b0);
        op84(8'hE7, 8'h39, 1'b1, 1'b1, lat, s, c, v);
        checks++; if ({s, c, v} !== {e1.s[7:0], e1.c, e1.v})
            begin errors++; $display("FAIL b2b_first: got %h %b %b expected %h %b %b", s, c, v, e1.s[7:0], e1.c, e1.v); end
        if84.start = 1'b1; if84.a = 8'h64; if84.b = 8'h2B; if84.c_in = 1'b1; if84.sub = 1'b0;
        @(negedge clk);
        if84.start = 1'b0;
        checks++; if (if84.valid !== 1'b0 || if84.ready !== 1'b0)
            begin errors++; $display("FAIL b2b_accept: got valid=%b ready=%b expected 0/0", if84.valid, if84.ready); end
        lat = 0;
        while (!if84.valid && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== 2 || {if84.s, if84.c_out, if84.ovf} !== {e2.s[7:0], e2.c, e2.v})
            begin errors++; $display("FAIL b2b_second: got lat=%0d %h %b %b expected 2 %h %b %b", lat, if84.s, if84.c_out, if84.ovf, e2.s[7:0], e2.c, e2.v); end
    endtask

    task automatic test_abort();
        int lat, nval; logic [7:0] s, a, b; logic c, v; res_t e;
        @(negedge clk);
        if84.start = 1'b1; if84.a = 8'hF3; if84.b = 8'h4E; if84.c_in = 1'b1; if84.sub = 1'b0;
        @(negedge clk);
        if84.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({if84.s, if84.c_out, if84.ovf, if84.valid, if84.ready} !== {8'h00, 4'b0001})
            begin errors++; $display("FAIL abort_outputs: got s=%h c=%b ovf=%b valid=%b ready=%b expected 00 0 0 0 1", if84.s, if84.c_out, if84.ovf, if84.valid, if84.ready); end
        @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (if84.valid) nval++; end
        checks++; if (nval !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", nval); end
        a = 8'($urandom); b = 8'($urandom);
        e = ref_model(8, longint'(a), longint'(b), 1'b0, 1'b1);
        op84(a, b, 1'b0, 1'b1, lat, s, c, v);
        checks++; if (lat !== 2 || {s, c, v} !== {e.s[7:0], e.c, e.v})
            begin errors++; $display("FAIL abort_recover: got lat=%0d %h %b %b expected 2 %h %b %b", lat, s, c, v, e.s[7:0], e.c, e.v); end
    endtask

    task automatic test_digit1();
        int lat; logic [7:0] s, a, b; logic c, v, cin, sb; res_t e;
        op81(8'hFF, 8'h01, 1'b0, 1'b0, lat, s, c, v);
        checks++; if (lat !== 8) begin errors++; $display("FAIL d1_latency: got %0d expected 8", lat); end
        checks++; if ({s, c, v} !== {8'h00, 2'b10}) begin errors++; $display("FAIL d1_result: got %h %b %b expected 00 1 0", s, c, v); end
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sb = 1'($urandom);
            e = ref_model(8, longint'(a), longint'(b), cin, sb);
            op81(a, b, cin, sb, lat, s, c, v);
            checks++; if (lat !== 8 || {s, c, v} !== {e.s[7:0], e.c, e.v})
                begin errors++; $display("FAIL d1_rand_%0d: got lat=%0d %h %b %b expected 8 %h %b %b", i, lat, s, c, v, e.s[7:0], e.c, e.v); end
        end
    endtask

    task automatic test_wide();
        int lat; logic [15:0] s, a, b; logic c, v, cin, sb; res_t e;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sb = 1'($urandom);
            if (i == 0) begin a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sb = 1'b0; end
            if (i == 1) begin a = 16'h8000; b = 16'h0000; cin = 1'b1; sb = 1'b1; end
            e = ref_model(16, longint'(a), longint'(b), cin, sb);
            op168(a, b, cin, sb, lat, s, c, v);
            checks++; if (lat !== 2 || {s, c, v} !== {e.s, e.c, e.v})
                begin errors++; $display("FAIL w16_rand_%0d: got lat=%0d %h %b %b expected 2 %h %b %b", i, lat, s, c, v, e.s, e.c, e.v); end
        end
    endtask

    initial begin
        if84.start = 1'b0;  if84.a = '0;  if84.b = '0;  if84.c_in = 1'b0;  if84.sub = 1'b0;
        if81.start = 1'b0;  if81.a = '0;  if81.b = '0;  if81.c_in = 1'b0;  if81.sub = 1'b0;
        if168.start = 1'b0; if168.a = '0; if168.b = '0; if168.c_in = 1'b0; if168.sub = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_random_84();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_digit1();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/digit_serial_cpa.md
# digit_serial_cpa

Parametrised, multi-cycle carry-propagate adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple stage. It is the clocked successor to the 4-bit combinational CPA. It sits wherever a wide add/sub can trade latency for area, and uses a start/valid handshake to talk to the surrounding datapath controller.

## Interface
- WIDTH, default 8: operand/result width. Must be ≥2 and a multiple of DIGIT.
- DIGIT, default 4: bits added per cycle. Must be ≥1. N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- sub  in  1  0: a+b+c_in; 1: a−b−c_in.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- c_in  in  1  carry-in (add) or borrow-in (sub); captured on accepted start.
- ready  out  1  high in IDLE/DONE; low while RUN.
- valid  out  1  one-cycle pulse, high when a new result is presented.
- s  out  WIDTH  result.
- c_out  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start is accepted.
- RUN → DONE after the N-th digit.
- DONE → RUN when start is high, otherwise DONE → IDLE.
- On accept, the block latches:
  - A = a
  - B' = sub ? ~b : b
  - carry = c_in ^ sub
  - digit counter = 0
- Each RUN cycle k (0..N−1):
  - {carry, r[k*DIGIT +: DIGIT]} = A[k] + B'[k] + carry, where A[k] and B'[k] are the k-th DIGIT-bit slices.
  - Internal result register r is separate from s. s is not disturbed during RUN.
- At the end of digit N−1:
  - s ← r (final)
  - c_out ← final carry
  - ovf ← (A[W−1] == B'[W−1]) && (r[W−1] != A[W−1])
- All arithmetic is modulo 2^WIDTH. No width extension.
- s, c_out and ovf hold their last result until the next operation completes.
- start while ready=0 is ignored. It is not queued, and operands are not re-captured.
- Reset, asynchronous at any time including mid-RUN, does all of the following:
  - state → IDLE
  - s, c_out, ovf, valid → 0
  - ready → 1
  - internal registers cleared
  - an aborted operation never asserts valid.

## Timing
- Start is accepted at edge E0. Digits are computed at edges E1..EN.
- ready: low from after E0 until after EN.
- valid: high for the one cycle following EN.
- s, c_out and ovf update at EN.
- Latency from accepted start to valid is N cycles. Throughput is one result per N cycles.
- Back-to-back: start high during the valid cycle (ready=1) is accepted at that edge. The next result follows N cycles later, with no idle gap.
- Simultaneous valid and start: valid still drops after one cycle.

## Configuration
- Macro DSA_SAT_EN.
  - Defined: when ovf=1 at completion, s is clamped to the signed extreme. It becomes 1 followed by WIDTH−1 zeros if A[W−1]=1, and 0 followed by WIDTH−1 ones otherwise. ovf is still reported as 1, and c_out is unaffected.
  - Undefined: s wraps modulo 2^WIDTH.

## Test plan
All scenarios use WIDTH=8, DIGIT=4 (N=2) unless stated.
- Reset: rst_n=0 with random inputs -> s=0, c_out=0, ovf=0, valid=0, ready=1.
- Add: a=8'h3C, b=8'h55, c_in=1, sub=0, start at E0 -> valid after E2.
  - Without macro: s=8'h92, c_out=0, ovf=1.
  - With DSA_SAT_EN: s=8'h7F.
- Subtract: a=8'h10, b=8'h20, c_in=0, sub=1 -> s=8'hF0, c_out=0, ovf=0.
  - Then a=8'h20, b=8'h10, c_in=1 -> s=8'h0F, c_out=1, ovf=0.
- Handshake:
  - start pulsed during RUN with different operands -> ignored; result matches the first operands.
  - start held in the valid cycle -> second result valid exactly 2 cycles later.
- Abort: rst_n low for one cycle after E1 -> no valid pulse, outputs 0; the next start works normally.
- Width/digit sweep: WIDTH=8, DIGIT=1, a=8'hFF, b=8'h01, add -> valid 8 cycles after start, s=8'h00, c_out=1, ovf=0.
  - Repeat with WIDTH=16, DIGIT=8 against a reference model over random vectors.
